fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// FifoWrArb: round-robin, packet-locking write arbiter feeding a sync FIFO.
//
// Up to NREQ requesters compete for the FIFO write port. After one idle
// cycle of arbitration, the chosen requester keeps the port until it sends
// its last beat or until it reaches MAXBEATS beats. When the beat limit is
// reached, the packet is force-released and err_overrun pulses for one cycle.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : synchronous, active-low reset
//   req_valid    : [NREQ]        per-requester beat valid
//   req_data     : [NREQ*DWIDTH] requester i at [i*DWIDTH +: DWIDTH]
//   req_last     : [NREQ]        per-requester end-of-packet marker
//   req_ready    : [NREQ]        beat accept, one-hot or zero
//   fifo_full    : downstream FIFO full flag
//   fifo_winc    : FIFO write strobe
//   fifo_wdata   : [DWIDTH] FIFO write data (always the owner's data)
//   grant_id     : [$clog2(NREQ)] current / most recent owner
//   busy         : high while a packet owns the port
//   pkt_count    : [16] completed packets, wraps
//   err_overrun  : one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int DWIDTH   = 8,
    parameter int MAXBEATS = 16,
    localparam int GW      = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_winc,
    output logic [DWIDTH-1:0]      fifo_wdata,
    output logic [GW-1:0]          grant_id,
    output logic                   busy,
    output logic [15:0]            pkt_count,
    output logic                   err_overrun
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t        r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_rrPtr;
    logic [7:0]    r_beatCnt;
    logic [15:0]   r_pktCount;
    logic          r_errOverrun;

    logic          w_lock;
    logic          w_ownValid;
    logic          w_ownLast;
    logic          w_atLimit;
    logic          w_release;
    logic          w_found;
    logic [GW-1:0] w_nextGrant;
    logic [GW-1:0] w_grantPlus1;

    // Round-robin search: first valid requester starting at r_rrPtr,
    // wrapping modulo NREQ (NREQ need not be a power of two).
    always_comb begin
        int w_idx;
        w_found     = 1'b0;
        w_nextGrant = r_rrPtr;
        w_idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_rrPtr) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found     = 1'b1;
                w_nextGrant = GW'(w_idx);
            end
        end
    end

    assign w_lock       = (r_state == ST_LOCK);
    assign w_ownValid   = req_valid[r_grant];
    assign w_ownLast    = req_last[r_grant];
    assign w_atLimit    = (r_beatCnt == 8'(MAXBEATS - 1));
    assign w_release    = fifo_winc && (w_ownLast || w_atLimit);
    assign w_grantPlus1 = (r_grant == GW'(NREQ - 1)) ? '0 : r_grant + 1'b1;

    // The write strobe never fires while the FIFO reports full, even if a
    // read would free space in the same cycle.
    assign fifo_winc  = w_lock && w_ownValid && !fifo_full;
    assign fifo_wdata = req_data[int'(r_grant)*DWIDTH +: DWIDTH];

    // Only the owner can see ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (w_lock && !fifo_full) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    assign grant_id    = r_grant;
    assign busy        = w_lock;
    assign pkt_count   = r_pktCount;
    assign err_overrun = r_errOverrun;

    // Arbitration FSM. IDLE spends exactly one cycle latching the winner.
    // LOCK holds the grant until a last beat or the beat limit, then returns
    // to IDLE with the pointer just past the finished owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_rrPtr      <= '0;
            r_beatCnt    <= '0;
            r_pktCount   <= '0;
            r_errOverrun <= 1'b0;
        end else begin
            r_errOverrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_beatCnt <= '0;
                    if (w_found) begin
                        r_grant <= w_nextGrant;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_release) begin
                        r_state      <= ST_IDLE;
                        r_rrPtr      <= w_grantPlus1;
                        r_pktCount   <= r_pktCount + 16'd1;
                        r_beatCnt    <= '0;
                        r_errOverrun <= !w_ownLast;
                    end else if (fifo_winc) begin
                        r_beatCnt <= r_beatCnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// Testbench for fifo_wr_arb. Randomised requesters, random FIFO full and
// occasional mid-run resets; every output is compared each cycle against a
// packet-level reference model kept here.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

    localparam int NREQ     = 4;
    localparam int DWIDTH   = 8;
    localparam int MAXBEATS = 4;
    localparam int GW       = $clog2(NREQ);
    localparam int NCYCLES  = 4000;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_full;
    logic                   fifo_winc;
    logic [DWIDTH-1:0]      fifo_wdata;
    logic [GW-1:0]          grant_id;
    logic                   busy;
    logic [15:0]            pkt_count;
    logic                   err_overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner is -1 when nobody holds the port.
    int mOwner, mRr, mGid, mBeats, mPkt;
    bit mErr;

    // Requester state: beats already sent (sequence number) and beats left
    // in the packet currently being offered.
    int seqNo  [NREQ];
    int remain [NREQ];
    int resetLeft = 0;
    int overruns  = 0;
    int packets   = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NREQ     (NREQ),
        .DWIDTH   (DWIDTH),
        .MAXBEATS (MAXBEATS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_winc   (fifo_winc),
        .fifo_wdata  (fifo_wdata),
        .grant_id    (grant_id),
        .busy        (busy),
        .pkt_count   (pkt_count),
        .err_overrun (err_overrun)
    );

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Each beat carries its requester id and sequence number so that a
    // lost, repeated or misrouted beat shows up in the write data.
    function automatic logic [DWIDTH-1:0] beatData(input int id);
        logic [2:0] idBits;
        logic [4:0] seqBits;
        idBits  = 3'(id);
        seqBits = 5'(seqNo[id]);
        return {idBits, seqBits};
    endfunction

    // Drive all inputs for the coming cycle, including the reset decision.
    task automatic applyStimulus();
        if (resetLeft == 0 && $urandom_range(0, 199) == 0) begin
            resetLeft = $urandom_range(1, 3);
        end
        rst_n = (resetLeft == 0);
        if (resetLeft > 0) resetLeft--;
        for (int i = 0; i < NREQ; i++) begin
            if (remain[i] == 0) remain[i] = $urandom_range(1, 6);
            req_valid[i]                 = ($urandom_range(0, 9) < 7);
            req_last[i]                  = (remain[i] == 1);
            req_data[i*DWIDTH +: DWIDTH] = beatData(i);
        end
        fifo_full = ($urandom_range(0, 9) < 3);
    endtask

    task automatic modelReset();
        mOwner = -1;
        mRr    = 0;
        mGid   = 0;
        mBeats = 0;
        mPkt   = 0;
        mErr   = 1'b0;
        for (int i = 0; i < NREQ; i++) remain[i] = 0;
    endtask

    initial begin
        logic [NREQ-1:0] expReady;
        bit              expWinc;
        bit              isLast;

        for (int i = 0; i < NREQ; i++) begin
            seqNo[i]  = 0;
            remain[i] = 0;
        end
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;

        for (int cyc = 0; cyc < NCYCLES; cyc++) begin
            if (cyc < 3) begin
                rst_n = 1'b1;
                req_valid = '0;
                fifo_full = 1'b0;
            end else begin
                applyStimulus();
            end
            @(negedge clk);

            expWinc  = (mOwner >= 0) && req_valid[mOwner] && !fifo_full;
            expReady = '0;
            if (mOwner >= 0 && !fifo_full) expReady = NREQ'(1) << mOwner;

            checkOutput("req_ready",   32'(req_ready),   32'(expReady));
            checkOutput("fifo_winc",   32'(fifo_winc),   32'(expWinc));
            checkOutput("fifo_wdata",  32'(fifo_wdata),  32'(beatData(mGid)));
            checkOutput("grant_id",    32'(grant_id),    32'(mGid));
            checkOutput("busy",        32'(busy),        32'(mOwner >= 0));
            checkOutput("pkt_count",   32'(pkt_count),   32'(mPkt));
            checkOutput("err_overrun", 32'(err_overrun), 32'(mErr));

            // Advance the model to the state after the coming rising edge.
            if (!rst_n) begin
                modelReset();
            end else begin
                mErr = 1'b0;
                if (mOwner < 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (mOwner < 0 && req_valid[(mRr + k) % NREQ]) begin
                            mOwner = (mRr + k) % NREQ;
                            mGid   = mOwner;
                        end
                    end
                end else if (expWinc) begin
                    isLast = (remain[mOwner] == 1);
                    seqNo[mOwner]++;
                    remain[mOwner]--;
                    mBeats++;
                    if (isLast || mBeats == MAXBEATS) begin
                        mPkt = (mPkt + 1) % 65536;
                        mErr = !isLast;
                        if (!isLast) overruns++;
                        packets++;
                        mRr    = (mOwner + 1) % NREQ;
                        mOwner = -1;
                        mBeats = 0;
                    end
                end
            end

            @(posedge clk);
            #1;
        end

        checkOutput("sawOverrun", 32'(overruns > 0), 32'd1);
        checkOutput("sawPackets", 32'(packets > 50), 32'd1);
        $display("[TB] packets=%0d overruns=%0d", packets, overruns);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
